// File: rtl/tx_rx_pkg.sv
// tx_rx_pkg: frame geometry and TX state encoding shared by the serial TX and RX sides
package tx_rx_pkg;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int ADR_W = $clog2(WORDS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SHIFT,
        GAP,
        WAIT_FIN
    } tx_state_t;

endpackage

// File: rtl/shift_reg_TX.sv
// shift_reg_TX: parallel-in serial-out register, MSB first, load wins over shift
module shift_reg_TX #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] r_q;

    assign msb = r_q[WIDTH-1];

    // load a new word or move the next bit into the MSB position
    always_ff @(posedge clk or negedge clr)
        if (!clr)
            r_q <= '0;
        else if (load)
            r_q <= din;
        else if (shift)
            r_q <= {r_q[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/tx_serializer.sv
// tx_serializer: host-written frame buffer sent word by word, MSB first, under a receiver handshake
module tx_serializer #(
    parameter int WIDTH = tx_rx_pkg::WIDTH,
    parameter int WORDS = tx_rx_pkg::WORDS,
    localparam int AW = $clog2(WORDS),
    localparam int BW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             rx_ready,
    input  logic             rx_finish,
    output logic             tx_vld,
    output logic             tx_data,
    output logic             busy,
    output logic             done
);

    import tx_rx_pkg::*;

    tx_state_t        r_state, w_next;
    logic [WIDTH-1:0] r_buf [WORDS];
    logic [AW-1:0]    r_word_cnt;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_tx_vld, r_tx_data;
    logic             w_load, w_shift, w_msb, w_last_bit, w_more;
    logic [WIDTH-1:0] w_din;

    assign w_last_bit = r_bit_cnt == BW'(WIDTH - 1);
    assign w_more     = r_word_cnt != AW'(WORDS - 1);
    assign busy       = r_state != IDLE;
    assign tx_vld     = r_tx_vld;
    assign tx_data    = r_tx_data;

    // state register
    always_ff @(posedge clk or negedge clr)
        if (!clr)
            r_state <= IDLE;
        else
            r_state <= w_next;

    // next state, PISO load/shift and the done pulse (done is combinational so it overlaps busy)
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_din   = r_buf[0];
        done    = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_load = 1'b1;
                w_next = WAIT_RDY;
            end
            WAIT_RDY: if (rx_ready) w_next = SHIFT;
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last_bit) begin
                    w_load = w_more;
                    w_din  = r_buf[r_word_cnt + AW'(1)];
                    w_next = w_more ? GAP : WAIT_FIN;
                end
            end
            GAP: w_next = WAIT_RDY;
            WAIT_FIN: if (rx_finish) begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // bit and word counters, cleared by an accepted start
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            r_word_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (r_state == IDLE && start) begin
            r_word_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (r_state == SHIFT) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
            if (w_last_bit && w_more)
                r_word_cnt <= r_word_cnt + AW'(1);
        end

    // frame buffer, host writes only while idle so a frame in flight cannot change
    always_ff @(posedge clk or negedge clr)
        if (!clr)
            for (int i = 0; i < WORDS; i++)
                r_buf[i] <= '0;
        else if (wr_en && !busy)
            r_buf[wr_addr] <= wr_data;

    // registered serial outputs, data forced low outside a valid bit
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            r_tx_vld  <= 1'b0;
            r_tx_data <= 1'b0;
        end else begin
            r_tx_vld  <= r_state == SHIFT;
            r_tx_data <= r_state == SHIFT && w_msb;
        end

    shift_reg_TX #(.WIDTH(WIDTH)) u_piso (
        .clk   (clk),
        .clr   (clr),
        .load  (w_load),
        .shift (w_shift),
        .din   (w_din),
        .msb   (w_msb)
    );

endmodule
